// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bridge: FSM encoding, default slot map
// and a small sizing helper.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Default peripheral slots: two timer blocks and the interrupt generator.
    localparam logic [31:0] TC0_BASE = 32'h0000_7f00;
    localparam logic [31:0] TC1_BASE = 32'h0000_7f10;
    localparam logic [31:0] INT_BASE = 32'h0000_7f20;
    localparam logic [31:0] TC_MASK  = 32'hffff_fff0;
    localparam logic [31:0] INT_MASK = 32'hffff_fffc;

    localparam logic [3*32-1:0] DEFAULT_SLV_BASE  = {INT_BASE, TC1_BASE, TC0_BASE};
    localparam logic [3*32-1:0] DEFAULT_SLV_MASK  = {INT_MASK, TC_MASK, TC_MASK};
    localparam logic [2:0]      DEFAULT_WORD_ONLY = 3'b011;

    // Width of a slot index; a single slot still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_decode.sv
// Combinational address decoder: base/mask match per slot, lowest index
// wins, and flags partial-width writes to word-only slots.
module mmio_decode import mmio_pkg::*; #(
    parameter int                   NUM_SLV   = 3,
    parameter int                   IDX_W     = 2,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE = DEFAULT_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK = DEFAULT_SLV_MASK,
    parameter logic [NUM_SLV-1:0]   WORD_ONLY = DEFAULT_WORD_ONLY
) (
    input  logic [31:0]      addr,
    input  logic [3:0]       byteen,
    output logic             hit,
    output logic [IDX_W-1:0] idx,
    output logic             word_only_violation
);

    // Scan from the highest slot down so the lowest matching index is the
    // last one written and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a
        // path with no hit would leave it unassigned and infer a latch.
        hit                 = 1'b0;
        idx                 = '0;
        word_only_violation = 1'b0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit                 = 1'b1;
                idx                 = IDX_W'(i);
                word_only_violation = WORD_ONLY[i] && (byteen != 4'b0000)
                                      && (byteen != 4'b1111);
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// Registered MMIO bridge: accepts one CPU access at a time, forwards it to
// the decoded peripheral slot with a ready handshake and a bounded wait,
// and returns exactly one response per accepted request.
module mmio_bridge import mmio_pkg::*; #(
    parameter int                    NUM_SLV   = 3,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE  = DEFAULT_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK  = DEFAULT_SLV_MASK,
    parameter logic [NUM_SLV-1:0]    WORD_ONLY = DEFAULT_WORD_ONLY,
    parameter int                    TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [3:0]            cpu_byteen,
    input  logic                  cpu_kill,
    output logic                  cpu_rvalid,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_err,
    output logic [NUM_SLV-1:0]    slv_sel,
    output logic [31:0]           slv_addr,
    output logic [31:0]           slv_wdata,
    output logic [3:0]            slv_byteen,
    input  logic [NUM_SLV*32-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]    slv_ready
);

    localparam int IDX_W = idx_width(NUM_SLV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_byteen;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_dec_hit;
    logic [IDX_W-1:0]   w_dec_idx;
    logic               w_dec_wov;
    logic               w_accept;
    logic               w_dec_ok;
    logic               w_sel_ready;
    logic [31:0]        w_sel_rdata;
    logic               w_timeout;

    mmio_decode #(
        .NUM_SLV   (NUM_SLV),
        .IDX_W     (IDX_W),
        .SLV_BASE  (SLV_BASE),
        .SLV_MASK  (SLV_MASK),
        .WORD_ONLY (WORD_ONLY)
    ) u_decode (
        .addr                (cpu_addr),
        .byteen              (cpu_byteen),
        .hit                 (w_dec_hit),
        .idx                 (w_dec_idx),
        .word_only_violation (w_dec_wov)
    );

    assign w_accept  = (r_state == ST_IDLE) && cpu_valid && !cpu_kill;
    assign w_dec_ok  = w_dec_hit && !w_dec_wov;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // Pick the ready/rdata of the latched slot; other slots are ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_sel_ready = slv_ready[i];
                w_sel_rdata = slv_rdata[i*32 +: 32];
            end
        end
    end

    // State register; reset returns to IDLE, which drops slv_sel at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every
            // register sees pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b0;
        cpu_rvalid   = 1'b0;
        slv_sel      = '0;
        case (r_state)
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = w_dec_ok ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    slv_sel[i] = (r_idx == IDX_W'(i));
                end
                if (w_sel_ready || w_timeout) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                cpu_rvalid   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_byteen <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= cpu_addr;
                        r_wdata  <= cpu_wdata;
                        r_byteen <= cpu_byteen;
                        r_idx    <= w_dec_idx;
                        r_cnt    <= '0;
                        if (!w_dec_ok) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_rdata <= (r_byteen == 4'b0000) ? w_sel_rdata : 32'h0;
                        r_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign slv_addr   = r_addr;
    assign slv_wdata  = r_wdata;
    assign slv_byteen = r_byteen;
    assign cpu_rdata  = r_rdata;
    assign cpu_err    = r_err;

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised, registered memory-mapped I/O bridge between the CPU data port and NUM_SLV peripheral slots (timers, interrupt generator, future devices). Decodes each CPU access against per-slot base/mask windows and forwards it with a valid/ready handshake. Enforces per-slot word-only write rules and bounds every access with a timeout. Returns exactly one response, read data or error, per accepted request. Sits between the CPU's M-stage data port and the peripheral bus; data memory stays outside it.

## Interface
- NUM_SLV, 3: number of peripheral slots (1..8).
- SLV_BASE, {32'h7f20, 32'h7f10, 32'h7f00}: packed NUM_SLV×32 base addresses; slot i occupies bits [32i+31:32i].
- SLV_MASK, {32'hffff_fffc, 32'hffff_fff0, 32'hffff_fff0}: packed NUM_SLV×32 decode masks; slot i is hit when (addr & mask_i) == base_i.
- WORD_ONLY, 3'b011: per-slot bit; a write to that slot with byteen != 4'b1111 is rejected with an error.
- TIMEOUT, 16: maximum ACCESS cycles before the bridge aborts (≥1).

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_valid  in  1  request present.
- cpu_ready  out  1  bridge can accept; high only in IDLE.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data.
- cpu_byteen  in  4  byte enables; nonzero means write, zero means read.
- cpu_kill  in  1  exception/interrupt in progress; drops the request in the accept cycle.
- cpu_rvalid  out  1  one-cycle response pulse.
- cpu_rdata  out  32  read data; valid with cpu_rvalid.
- cpu_err  out  1  unmapped, illegal-width or timeout; valid with cpu_rvalid.
- slv_sel  out  NUM_SLV  one-hot slot select.
- slv_addr  out  32  registered address.
- slv_wdata  out  32  registered write data.
- slv_byteen  out  4  registered byte enables; 0 means read.
- slv_rdata  in  NUM_SLV×32  packed read data; slot i occupies bits [32i+31:32i].
- slv_ready  in  NUM_SLV  slot completes the access this cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: cpu_ready=1.
  - cpu_valid & !cpu_kill: latch addr, wdata, byteen and the decoded index.
  - cpu_valid & cpu_kill: nothing is latched and no response is produced.
- Decode:
  - If several windows hit, the lowest index wins.
  - No hit, or a write with WORD_ONLY[i] set and byteen != 4'b1111: go to RESP with err=1. No slave sees the access.
  - Otherwise go to ACCESS.
- ACCESS:
  - slv_sel[i]=1; slv_addr, slv_wdata and slv_byteen are held constant.
  - The cycle counter starts at 0 and increments each cycle that slv_ready[i] is low.
  - slv_ready[i]=1: capture slv_rdata[i] for a read, or 0 for a write. Go to RESP with err=0.
  - Counter reaches TIMEOUT-1 with no ready: go to RESP with err=1 and rdata=0.
  - slv_ready bits of unselected slots are ignored.
- RESP: cpu_rvalid=1, cpu_ready=0, slv_sel=0; go to IDLE next cycle.
- cpu_kill is ignored outside IDLE; an accepted access always completes.
- Counter width is $clog2(TIMEOUT+1). Address decode is purely combinational on cpu_addr.

## Timing
- Reset values: state=IDLE, cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, cpu_err=0, slv_sel=0, slv_addr=0, slv_wdata=0, slv_byteen=0, counter=0.
- Reset asserted mid-ACCESS clears slv_sel asynchronously. No response is issued for the aborted access.
- Mapped access, zero wait states: accept at cycle 0, slv_sel high in cycle 1, cpu_rvalid in cycle 2. Each slave wait state adds one cycle.
- Unmapped or illegal access: accept at cycle 0, cpu_rvalid with err in cycle 1.
- Timeout: slv_sel is high for exactly TIMEOUT cycles; cpu_rvalid follows in the next cycle.
- Back-to-back: a new request can be accepted in the cycle after RESP. Throughput is at most one access per 3 cycles.
- cpu_rdata and cpu_err hold their values until the next response.

## Structure
- Shared package mmio_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - default slot bases (TC0 32'h7f00, TC1 32'h7f10, INT 32'h7f20) and masks.
- One sub-module, mmio_decode: combinational base/mask match plus priority encoder. Outputs hit, idx and word_only_violation.

## Test plan
- Read TC0 at 32'h7f04; slot 0 raises ready in cycle 1 with rdata 32'h1234 -> cpu_rvalid in cycle 2, rdata=32'h1234, err=0.
- Write 32'hA5A5 to 32'h7f10 with byteen=4'b0011 -> slv_sel never asserted; cpu_rvalid in cycle 1 with err=1.
- Read 32'h0000_5000 (unmapped) -> no slave select; cpu_rvalid, err=1, rdata=0 one cycle after accept.
- Read 32'h7f20 with slot 2 ready tied low, TIMEOUT=16 -> slv_sel[2] high for exactly 16 cycles, then cpu_rvalid with err=1.
- cpu_valid and cpu_kill high together on a write to 32'h7f00 -> slv_sel stays 0 and no cpu_rvalid. A write issued the next cycle completes normally.
- reset_n pulsed low in the second ACCESS cycle with slot 1 waiting -> slv_sel=0 immediately, all outputs at reset values, no rvalid. The following access is accepted.
